sys_cmd_host: RTL
=================

// Module: sys_cmd_host
// PURPOSE
//  Host-side command engine that drives the UART system top from outside. It accepts one transaction request
//  (RegFile write, RegFile read, ALU op with operands, ALU op without operands). It serialises the request into
//  the system's UART frame byte sequence on a byte-stream TX interface. It then collects the response bytes from
//  a byte-stream RX interface and returns one response word. It sits between a test/host controller and a UART
//  TX/RX pair wired to UART_RX_IN/UART_TX_O.
// PARAMETERS
//  DATA_WIDTH     8       byte width; fixed at 8 for frame compatibility
//  ADDR_WIDTH     4       RegFile address width; zero-extended to a byte on the wire
//  FUNC_WIDTH     4       ALU function width; zero-extended to a byte on the wire
//  TIMEOUT_CYCLES 65535   response wait limit in CLK cycles (used only with SYS_CMD_TIMEOUT_EN)
// PORTS
//  CLK        in   1    single clock
//  RST        in   1    synchronous, active-high reset
//  req_valid  in   1    request present
//  req_ready  out  1    high only in IDLE; transfer when req_valid&&req_ready
//  req_cmd    in   2    0=RF_WR 1=RF_RD 2=ALU_OP 3=ALU_NOP
//  req_addr   in   ADDR_WIDTH  RegFile address
//  req_a      in   8    write data (RF_WR) / operand A (ALU_OP)
//  req_b      in   8    operand B (ALU_OP)
//  req_func   in   FUNC_WIDTH  ALU function
//  tx_byte    out  8    byte to UART TX
//  tx_valid   out  1    byte valid; held with tx_byte stable until tx_ready
//  tx_ready   in   1    UART TX accepts byte this cycle
//  rx_byte    in   8    byte from UART RX
//  rx_valid   in   1    single-cycle strobe, rx_byte valid
//  rsp_valid  out  1    single-cycle strobe, response complete
//  rsp_data   out  16   response payload, held until next rsp_valid
//  rsp_err    out  1    qualifies rsp_valid: 1 = timeout (rsp_data=0)
//  stray_rx   out  1    pulse: rx byte received outside WAIT_RSP, byte dropped
//  busy       out  1    ~IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; tx_valid, rsp_valid, rsp_err, stray_rx, busy = 0; tx_byte, rsp_data = 0; counters = 0.
//  - FSM: IDLE -> SEND on accept. Request fields are registered, so inputs may change after accept.
//  - SEND -> WAIT_RSP after the last byte handshake for RF_RD/ALU_OP/ALU_NOP.
//  - SEND -> DONE after the last byte handshake for RF_WR.
//  - WAIT_RSP -> DONE after the expected byte count. DONE -> IDLE in 1 cycle.
//  - Frames, bytes in order:
//      RF_WR   AA, addr, a
//      RF_RD   BB, addr
//      ALU_OP  CC, a, b, func
//      ALU_NOP DD, func
//  - Expected response bytes: RF_WR 0, RF_RD 1, ALU_OP/ALU_NOP 2 (LSB first).
//  - tx_valid rises the cycle after accept. The next byte is presented the cycle after each handshake; there are
//    no bubbles beyond that. tx_byte/tx_valid must not change while tx_valid && !tx_ready.
//  - rsp_data: RF_RD = {8'h00, b0}; ALU = {b1, b0}; RF_WR = 16'h0000.
//  - DONE drives rsp_valid=1 for exactly one cycle. req_ready returns high the following cycle.
//  - Minimum RF_WR latency from accept to rsp_valid: 3 tx handshakes + 2 cycles.
//  - rx_valid in IDLE/SEND/DONE: byte dropped, stray_rx pulses the same cycle (registered, +1).
//  - Extra bytes are never merged into the next response.
//  - rx_valid on the same cycle as the final tx handshake is stray; WAIT_RSP starts next cycle.
//  - RST mid-frame: abort immediately and drop tx_valid next edge; no rsp_valid for the aborted request.
// CONFIGURATION
//  - SYS_CMD_TIMEOUT_EN defined: a counter runs in WAIT_RSP and clears on each rx byte.
//    - When it reaches TIMEOUT_CYCLES-1: go to DONE with rsp_err=1 and rsp_data=0.
//    - Partially received bytes are discarded.
//  - SYS_CMD_TIMEOUT_EN undefined: no counter; WAIT_RSP waits indefinitely.
//    - rsp_err is tied 0; TIMEOUT_CYCLES is ignored.
// STRUCTURE
//  - Shared package sys_cmd_pkg:
//    - cmd enum: RF_WR, RF_RD, ALU_OP, ALU_NOP.
//    - frame opcodes: 8'hAA, 8'hBB, 8'hCC, 8'hDD.
//    - state encoding: IDLE, SEND, WAIT_RSP, DONE.
//    - functions frame_len(cmd) and rsp_len(cmd).
//  - One sub-module, sys_cmd_frame_mux: combinational byte select from registered request + byte index.
//  - FSM, counters and response assembly stay in the top.
// TESTING
//  1. RF_WR addr=3 a=8'h21, tx_ready=1 -> tx AA,03,21 on consecutive handshakes; rsp_valid with rsp_data=0000.
//  2. RF_RD addr=2, reply rx 8'h81 -> tx BB,02; rsp_data=0081, rsp_err=0.
//  3. ALU_OP a=8'h0F b=8'h10 func=2, reply rx 8'hF0 then 8'h00 -> tx CC,0F,10,02; rsp_data=00F0.
//  4. ALU_NOP func=1 with tx_ready low 5 cycles on byte 2 -> tx_byte held at 01 through stall.
//     - rx 34,12 -> rsp_data=1234.
//  5. rx_valid in IDLE -> stray_rx pulse, no rsp_valid. RST asserted mid-SEND (after AA) -> tx_valid=0,
//     req_ready=1, no rsp_valid.
//  6. SYS_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, RF_RD with no reply -> rsp_valid, rsp_err=1, rsp_data=0000.
//     - The pulse occurs 16 cycles after WAIT_RSP entry.

Source files
------------

// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the host-side command engine.
//   cmd_t      : request command encoding (matches the 2-bit req_cmd port)
//   state_t    : engine FSM states
//   OP_*       : UART frame opcodes, first byte of every frame
//   frame_len  : number of bytes transmitted for a command
//   rsp_len    : number of response bytes expected for a command
package sys_cmd_pkg;

  typedef enum logic [1:0] {
    RF_WR   = 2'd0,
    RF_RD   = 2'd1,
    ALU_OP  = 2'd2,
    ALU_NOP = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [7:0] OP_RF_WR   = 8'hAA;
  localparam logic [7:0] OP_RF_RD   = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  function automatic logic [2:0] frame_len(input cmd_t cmd);
    case (cmd)
      RF_WR:   frame_len = 3'd3;
      RF_RD:   frame_len = 3'd2;
      ALU_OP:  frame_len = 3'd4;
      default: frame_len = 3'd2;
    endcase
  endfunction

  function automatic logic [1:0] rsp_len(input cmd_t cmd);
    case (cmd)
      RF_WR:   rsp_len = 2'd0;
      RF_RD:   rsp_len = 2'd1;
      default: rsp_len = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/sys_cmd_host_if.sv
// Bus bundle between a host controller and sys_cmd_host.
//   req_*  : request handshake and fields (host -> engine)
//   tx_*   : byte stream towards the UART transmitter
//   rx_*   : byte strobe from the UART receiver
//   rsp_*  : response strobe, payload and error qualifier
//   stray_rx, busy : status
// master = host controller side, slave = sys_cmd_host.
interface sys_cmd_host_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int FUNC_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  sys_cmd_pkg::cmd_t     req_cmd;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_a;
  logic [7:0]            req_b;
  logic [FUNC_WIDTH-1:0] req_func;
  logic [7:0]            tx_byte;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            rx_byte;
  logic                  rx_valid;
  logic                  rsp_valid;
  logic [15:0]           rsp_data;
  logic                  rsp_err;
  logic                  stray_rx;
  logic                  busy;

  modport master (
    output req_valid, req_cmd, req_addr, req_a, req_b, req_func,
           tx_ready, rx_byte, rx_valid,
    input  req_ready, tx_byte, tx_valid, rsp_valid, rsp_data, rsp_err,
           stray_rx, busy
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_a, req_b, req_func,
           tx_ready, rx_byte, rx_valid,
    output req_ready, tx_byte, tx_valid, rsp_valid, rsp_data, rsp_err,
           stray_rx, busy
  );
endinterface

// File: rtl/sys_cmd_frame_mux.sv
// Combinational frame byte selector.
//   cmd, addr, a, b, func : registered request fields
//   idx                   : byte position within the frame (0 = opcode)
//   byte_out              : byte to transmit; addr/func are zero-extended
module sys_cmd_frame_mux
  import sys_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUNC_WIDTH = 4
) (
  input  cmd_t                  cmd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [FUNC_WIDTH-1:0] func,
  input  logic [1:0]            idx,
  output logic [DATA_WIDTH-1:0] byte_out
);

  logic [DATA_WIDTH-1:0] addr_ext;
  logic [DATA_WIDTH-1:0] func_ext;

  assign addr_ext = DATA_WIDTH'(addr);
  assign func_ext = DATA_WIDTH'(func);

  always_comb begin
    byte_out = '0;
    case (cmd)
      RF_WR: begin
        case (idx)
          2'd0:    byte_out = OP_RF_WR;
          2'd1:    byte_out = addr_ext;
          default: byte_out = a;
        endcase
      end
      RF_RD: begin
        byte_out = (idx == 2'd0) ? OP_RF_RD : addr_ext;
      end
      ALU_OP: begin
        case (idx)
          2'd0:    byte_out = OP_ALU_OP;
          2'd1:    byte_out = a;
          2'd2:    byte_out = b;
          default: byte_out = func_ext;
        endcase
      end
      default: begin
        byte_out = (idx == 2'd0) ? OP_ALU_NOP : func_ext;
      end
    endcase
  end

endmodule

// File: rtl/sys_cmd_host.sv
// Host-side command engine for the UART system top.
// Accepts one request, serialises it as a UART frame on the tx byte stream,
// collects the response bytes from the rx strobe and returns one 16-bit word.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : sys_cmd_host_if.slave (request, tx, rx, response, status)
// Optional feature: define SYS_CMD_TIMEOUT_EN to bound the response wait to
// TIMEOUT_CYCLES cycles (response then flagged with rsp_err=1, rsp_data=0).
module sys_cmd_host
  import sys_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUNC_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic           CLK,
  input  logic           RST,
  sys_cmd_host_if.slave  bus
);

  state_t                state, state_n;
  cmd_t                  cmd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [FUNC_WIDTH-1:0] func_q;
  logic [1:0]            byte_idx;
  logic [1:0]            rx_cnt;
  logic [7:0]            rsp_lo;
  logic [15:0]           rsp_data_q;
  logic                  stray_q;
  logic [DATA_WIDTH-1:0] frame_byte;

  logic accept, tx_hs, tx_last, rx_hit, rx_last, timeout_hit;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign tx_hs   = (state == SEND) && bus.tx_ready;
  assign tx_last = ({1'b0, byte_idx} == (frame_len(cmd_q) - 3'd1));
  assign rx_hit  = (state == WAIT_RSP) && bus.rx_valid;
  assign rx_last = (rx_cnt == (rsp_len(cmd_q) - 2'd1));

`ifdef SYS_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          rsp_err_q;

  // Counts idle cycles in WAIT_RSP; any rx byte restarts the window.
  always_ff @(posedge CLK) begin
    if (RST || state != WAIT_RSP || bus.rx_valid) to_cnt <= '0;
    else                                          to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state == WAIT_RSP) && !bus.rx_valid &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  sys_cmd_frame_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FUNC_WIDTH (FUNC_WIDTH)
  ) u_frame_mux (
    .cmd      (cmd_q),
    .addr     (addr_q),
    .a        (a_q),
    .b        (b_q),
    .func     (func_q),
    .idx      (byte_idx),
    .byte_out (frame_byte)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (accept) state_n = SEND;
      SEND:     if (tx_hs && tx_last) state_n = (cmd_q == RF_WR) ? DONE : WAIT_RSP;
      WAIT_RSP: if ((rx_hit && rx_last) || timeout_hit) state_n = DONE;
      default:  state_n = IDLE;
    endcase
  end

  // Outputs; tx_byte depends only on registered fields and byte_idx, so it
  // holds through a stall because byte_idx only moves on a handshake.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.tx_valid  = (state == SEND);
    bus.tx_byte   = (state == SEND) ? frame_byte : '0;
    bus.rsp_valid = (state == DONE);
    bus.rsp_data  = rsp_data_q;
    bus.stray_rx  = stray_q;
`ifdef SYS_CMD_TIMEOUT_EN
    bus.rsp_err   = rsp_err_q;
`else
    bus.rsp_err   = 1'b0;
`endif
  end

  // Request capture, frame/response counters and response assembly
  always_ff @(posedge CLK) begin
    if (RST) begin
      cmd_q      <= RF_WR;
      addr_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      func_q     <= '0;
      byte_idx   <= '0;
      rx_cnt     <= '0;
      rsp_lo     <= '0;
      rsp_data_q <= '0;
      stray_q    <= 1'b0;
`ifdef SYS_CMD_TIMEOUT_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      // Bytes outside WAIT_RSP are dropped, including one coincident with
      // the final tx handshake.
      stray_q <= bus.rx_valid && (state != WAIT_RSP);

      if (accept) begin
        cmd_q    <= bus.req_cmd;
        addr_q   <= bus.req_addr;
        a_q      <= bus.req_a;
        b_q      <= bus.req_b;
        func_q   <= bus.req_func;
        byte_idx <= '0;
        rx_cnt   <= '0;
      end

      if (tx_hs) begin
        byte_idx <= tx_last ? 2'd0 : byte_idx + 2'd1;
        if (tx_last && cmd_q == RF_WR) begin
          rsp_data_q <= '0;
`ifdef SYS_CMD_TIMEOUT_EN
          rsp_err_q  <= 1'b0;
`endif
        end
      end

      if (rx_hit) begin
        if (rx_last) begin
          rsp_data_q <= (cmd_q == RF_RD) ? {8'h00, bus.rx_byte} : {bus.rx_byte, rsp_lo};
`ifdef SYS_CMD_TIMEOUT_EN
          rsp_err_q  <= 1'b0;
`endif
        end else begin
          rsp_lo <= bus.rx_byte;
          rx_cnt <= rx_cnt + 2'd1;
        end
      end

`ifdef SYS_CMD_TIMEOUT_EN
      if (timeout_hit) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end
`endif
    end
  end

endmodule
